hsem_ine_mc: RTL and testbench

//  Parametrised interrupt/error controller for the HSEM block, sized for NUM_CORES masters.
//  Per core it keeps a sticky error register, an error-overflow flag, an interrupt register and an enable mask.

---
 rtl/hsem_ine_mc.sv | 160 ++++++++++++++++
 tb/tb_hsem_ine_mc.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hsem_ine_mc.sv
// HSEM interrupt/error controller: per-core sticky error, overflow flag, interrupt
// register and enable mask, with a level or re-triggerable pulse interrupt line per core.

module hsem_ine_mc_lane #(
   parameter int            DW            = 32,
   parameter int            SW            = 32,
   parameter logic [DW-1:0] ERR_INTR_CODE = 'h1,
   parameter bit            PULSE         = 1'b0,
   parameter int            RETRIG        = 0,
   parameter int            CW            = 16
) (
   input  logic          hclk,
   input  logic          hresetn,
   input  logic          wr_en,
   input  logic [DW-1:0] hwdata,
   input  logic          int_sel,
   input  logic          int_clr,
   input  logic          err_sel,
   input  logic          err_clr,
   input  logic          msk_sel,
   input  logic [SW-1:0] semerr,
   output logic [DW-1:0] rdata,
   output logic          intr,
   output logic          err_ovf
);
   typedef enum logic [1:0] {IDLE, FIRE, WAIT} st_e;

   localparam logic [CW-1:0] RLOAD = (RETRIG == 0) ? '0 : CW'(RETRIG - 1);

   logic [SW-1:0] err_q, err_d;
   logic [DW-1:0] intr_q, intr_d;
   logic          ovf_q, ovf_d, mask_q, mask_d;
   st_e           st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_hit, pend;

   assign err_hit = (semerr != '0);
   assign pend    = mask_q & (intr_q != '0);

   always_comb begin
      err_d  = err_q;
      ovf_d  = ovf_q;
      intr_d = intr_q;
      mask_d = mask_q;
      if (err_clr) begin
         err_d = '0;
         ovf_d = 1'b0;
      end else if (err_hit) begin
         err_d = semerr;
         if (err_q != '0) ovf_d = 1'b1;
      end
      if (err_hit)                intr_d = ERR_INTR_CODE;
      else if (int_sel && wr_en)  intr_d = hwdata;
      else if (int_clr)           intr_d = '0;
      if (msk_sel && wr_en) mask_d = hwdata[0];
   end

   // FIRE always lasts one full cycle, even if pend drops underneath it
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      case (st_q)
         IDLE: if (pend) st_d = FIRE;
         FIRE: begin
            st_d  = WAIT;
            cnt_d = RLOAD;
         end
         WAIT: begin
            if (!pend)                st_d = IDLE;
            else if (RETRIG != 0) begin
               if (cnt_q == '0)       st_d = FIRE;
               else                   cnt_d = cnt_q - 1'b1;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         err_q  <= '0;
         ovf_q  <= 1'b0;
         intr_q <= '0;
         mask_q <= 1'b1;
         st_q   <= IDLE;
         cnt_q  <= '0;
      end else begin
         err_q  <= err_d;
         ovf_q  <= ovf_d;
         intr_q <= intr_d;
         mask_q <= mask_d;
         st_q   <= st_d;
         cnt_q  <= cnt_d;
      end
   end

   generate
      if (PULSE) begin : g_pulse
         assign intr = (st_q == FIRE);
      end else begin : g_level
         assign intr = pend;
      end
   endgenerate

   assign err_ovf = ovf_q;

   always_comb begin
      rdata = '0;
      if (int_sel) rdata = rdata | intr_q;
      if (err_sel) begin
         rdata[SW-1:0] = rdata[SW-1:0] | err_q;
         rdata[DW-1]   = rdata[DW-1] | ovf_q;
      end
      if (msk_sel) rdata[0] = rdata[0] | mask_q;
   end
endmodule

module hsem_ine_mc #(
   parameter int                   NUM_CORES     = 2,
   parameter int                   DW            = 32,
   parameter int                   SW            = 32,
   parameter logic [DW-1:0]        ERR_INTR_CODE = 'h1,
   parameter logic [NUM_CORES-1:0] INTR_MODE     = '0,
   parameter int                   RETRIG        = 0,
   parameter int                   CW            = 16
) (
   input  logic                    hclk,
   input  logic                    hresetn,
   input  logic                    wr_en,
   input  logic [DW-1:0]           hwdata,
   input  logic [NUM_CORES-1:0]    int_sel,
   input  logic [NUM_CORES-1:0]    int_clr,
   input  logic [NUM_CORES-1:0]    err_sel,
   input  logic [NUM_CORES-1:0]    err_clr,
   input  logic [NUM_CORES-1:0]    msk_sel,
   input  logic [NUM_CORES*SW-1:0] semerr,
   output logic [DW-1:0]           rdata,
   output logic [NUM_CORES-1:0]    intr,
   output logic [NUM_CORES-1:0]    err_ovf
);
   logic [NUM_CORES-1:0][DW-1:0] lane_rdata;

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
      hsem_ine_mc_lane #(
         .DW(DW), .SW(SW), .ERR_INTR_CODE(ERR_INTR_CODE),
         .PULSE(INTR_MODE[i]), .RETRIG(RETRIG), .CW(CW)
      ) u_lane (
         .hclk(hclk), .hresetn(hresetn), .wr_en(wr_en), .hwdata(hwdata),
         .int_sel(int_sel[i]), .int_clr(int_clr[i]), .err_sel(err_sel[i]),
         .err_clr(err_clr[i]), .msk_sel(msk_sel[i]), .semerr(semerr[i*SW +: SW]),
         .rdata(lane_rdata[i]), .intr(intr[i]), .err_ovf(err_ovf[i])
      );
   end

   // selects are one-hot by contract; overlapping selects simply OR
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_CORES; i++) rdata = rdata | lane_rdata[i];
   end
endmodule

// File: tb/tb_hsem_ine_mc.sv
// Directed bench for hsem_ine_mc: core 0 level mode, core 1 pulse mode with RETRIG=3.
module tb_hsem_ine_mc;
   localparam int NC = 2, DW = 32, SW = 32, RT = 3;
   localparam logic [1:0]    MODE = 2'b10;
   localparam logic [31:0]   CODE = 32'h1;

   logic           hclk = 1'b0, hresetn = 1'b0, wr_en = 1'b0;
   logic [DW-1:0]  hwdata = '0;
   logic [NC-1:0]  int_sel = '0, int_clr = '0, err_sel = '0, err_clr = '0, msk_sel = '0;
   logic [NC*SW-1:0] semerr = '0;
   logic [DW-1:0]  rdata;
   logic [NC-1:0]  intr, err_ovf;

   int errors = 0, checks = 0;

   hsem_ine_mc #(.NUM_CORES(NC), .DW(DW), .SW(SW), .ERR_INTR_CODE(CODE),
                 .INTR_MODE(MODE), .RETRIG(RT), .CW(16)) dut (
      .hclk(hclk), .hresetn(hresetn), .wr_en(wr_en), .hwdata(hwdata),
      .int_sel(int_sel), .int_clr(int_clr), .err_sel(err_sel), .err_clr(err_clr),
      .msk_sel(msk_sel), .semerr(semerr), .rdata(rdata), .intr(intr), .err_ovf(err_ovf));

   always #5 hclk = ~hclk;

   // Model: register contents plus "cycles since last pulse" (-1 = no pulse episode)
   logic [31:0] m_err [NC];
   logic [31:0] m_iq  [NC];
   bit          m_ovf [NC];
   bit          m_msk [NC];
   int          since [NC];

   initial for (int i = 0; i < NC; i++) begin
      m_err[i] = 0; m_iq[i] = 0; m_ovf[i] = 0; m_msk[i] = 1; since[i] = -1;
   end

   always @(posedge hclk) begin
      for (int i = 0; i < NC; i++) begin
         if (!hresetn) begin
            m_err[i] = 0; m_iq[i] = 0; m_ovf[i] = 0; m_msk[i] = 1; since[i] = -1;
         end else begin
            bit pend;
            logic [31:0] sem;
            pend = m_msk[i] && (m_iq[i] != 0);
            sem  = semerr[i*SW +: SW];
            if (since[i] < 0)       since[i] = pend ? 0 : -1;
            else if (since[i] == 0) since[i] = 1;
            else if (!pend)         since[i] = -1;
            else if (RT > 0 && since[i] == RT) since[i] = 0;
            else if (since[i] < 1000) since[i] = since[i] + 1;
            if (err_clr[i]) begin m_ovf[i] = 0; m_err[i] = 0; end
            else if (sem != 0) begin
               if (m_err[i] != 0) m_ovf[i] = 1;
               m_err[i] = sem;
            end
            if (sem != 0)                   m_iq[i] = CODE;
            else if (int_sel[i] && wr_en)   m_iq[i] = hwdata;
            else if (int_clr[i])            m_iq[i] = 0;
            if (msk_sel[i] && wr_en)        m_msk[i] = hwdata[0];
         end
      end
   end

   always @(negedge hclk) begin
      logic [31:0] e_rd;
      logic [NC-1:0] e_intr, e_ovf;
      e_rd = 0;
      for (int i = 0; i < NC; i++) begin
         e_intr[i] = MODE[i] ? (since[i] == 0) : (m_msk[i] && m_iq[i] != 0);
         e_ovf[i]  = m_ovf[i];
         if (int_sel[i]) e_rd = e_rd | m_iq[i];
         if (err_sel[i]) e_rd = e_rd | {m_ovf[i], 31'b0} | m_err[i];
         if (msk_sel[i]) e_rd = e_rd | {31'b0, m_msk[i]};
      end
      checks++;
      if (intr !== e_intr || err_ovf !== e_ovf || rdata !== e_rd) begin
         errors++;
         $display("FAIL model t=%0t: intr=%b/%b ovf=%b/%b rdata=%h/%h (got/expected)",
                  $time, intr, e_intr, err_ovf, e_ovf, rdata, e_rd);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge hclk); #1;
   endtask

   task automatic quiet();
      wr_en = 0; hwdata = 0; int_sel = 0; int_clr = 0;
      err_sel = 0; err_clr = 0; msk_sel = 0; semerr = 0;
   endtask

   logic [8:0] pulses;

   initial begin
      // T1 reset
      cyc(); cyc();
      chk("rst_intr", 32'(intr), 0);
      chk("rst_ovf", 32'(err_ovf), 0);
      chk("rst_rdata", rdata, 0);
      msk_sel = 2'b01; #1 chk("rst_mask0", rdata, 1);
      msk_sel = 2'b10; #1 chk("rst_mask1", rdata, 1);
      msk_sel = 0; hresetn = 1;
      cyc();

      // T2 error raise and clear on core 0
      semerr[31:0] = 5; cyc(); quiet();
      err_sel = 2'b01; #1 chk("t2_err", rdata, 5);
      chk("t2_intr", 32'(intr[0]), 1);
      err_sel = 0; int_sel = 2'b01; #1 chk("t2_iq", rdata, CODE);
      int_sel = 0; err_clr = 2'b01; int_clr = 2'b01; cyc(); quiet();
      #1 chk("t2_intr_clr", 32'(intr[0]), 0);
      err_sel = 2'b01; #1 chk("t2_err_clr", rdata, 0);
      quiet();

      // T3 overflow and clear-vs-error priority
      semerr[31:0] = 3; cyc(); semerr[31:0] = 7; cyc(); quiet();
      err_sel = 2'b01; #1 chk("t3_err_ovf", rdata, 32'h8000_0007);
      chk("t3_ovf", 32'(err_ovf), 1);
      err_sel = 0; err_clr = 2'b01; semerr[31:0] = 9; cyc(); quiet();
      err_sel = 2'b01; #1 chk("t3_clr_wins", rdata, 0);
      err_sel = 0; int_clr = 2'b01; cyc(); quiet();

      // T4 error beats register write
      int_sel = 2'b01; wr_en = 1; hwdata = 32'hA5; semerr[31:0] = 2; cyc(); quiet();
      int_sel = 2'b01; #1 chk("t4_err_wins", rdata, CODE);
      wr_en = 1; hwdata = 32'hA5; cyc(); quiet();
      int_sel = 2'b01; #1 chk("t4_write", rdata, 32'hA5);
      chk("t4_intr", 32'(intr[0]), 1);
      quiet();

      // T5 mask, level core 0 then pulse core 1
      msk_sel = 2'b01; wr_en = 1; hwdata = 0; cyc(); quiet();
      #1 chk("t5_masked", 32'(intr[0]), 0);
      int_sel = 2'b01; #1 chk("t5_iq_kept", rdata, 32'hA5);
      quiet(); msk_sel = 2'b01; wr_en = 1; hwdata = 1; cyc(); quiet();
      #1 chk("t5_unmasked", 32'(intr[0]), 1);
      msk_sel = 2'b10; wr_en = 1; hwdata = 0; cyc(); quiet();
      int_sel = 2'b10; wr_en = 1; hwdata = 1; cyc(); quiet();
      cyc(); cyc();
      chk("t5_p_masked", 32'(intr[1]), 0);
      msk_sel = 2'b10; wr_en = 1; hwdata = 1; cyc(); quiet();
      chk("t5_p_pre", 32'(intr[1]), 0);
      cyc(); chk("t5_p_pulse", 32'(intr[1]), 1);
      cyc(); chk("t5_p_end", 32'(intr[1]), 0);
      int_clr = 2'b10; cyc(); quiet(); cyc(); cyc();

      // T6 re-trigger every RETRIG+1 cycles, then clear, then reset during WAIT
      int_sel = 2'b10; wr_en = 1; hwdata = 3; cyc(); quiet();
      for (int k = 1; k <= 9; k++) begin cyc(); pulses[k-1] = intr[1]; end
      chk("t6_pulses", 32'(pulses), 32'b1_0001_0001);
      int_clr = 2'b10; cyc(); quiet();
      pulses = 0;
      for (int k = 1; k <= 9; k++) begin cyc(); pulses[k-1] = intr[1]; end
      chk("t6_after_clr", 32'(pulses), 0);
      int_sel = 2'b10; wr_en = 1; hwdata = 7; cyc(); quiet();
      cyc(); cyc(); cyc();
      hresetn = 0; cyc(); hresetn = 1;
      pulses = 0;
      for (int k = 1; k <= 9; k++) begin cyc(); pulses[k-1] = intr[1]; end
      chk("t6_rst_wait", 32'(pulses), 0);
      int_sel = 2'b11; #1 chk("t6_rst_iq", rdata, 0);
      quiet(); cyc(); cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
